sad_acc: RTL

Parametrised, elastic sum-of-absolute-differences (SAD) engine. Each beat carries N lanes of W-bit unsigned samples x and y. The block computes the sum of |x_i - y_i| across all lanes and accumulates that sum over a multi-beat frame delimited by in_last. It sits between a block-fetch unit and a motion-search comparator, with valid/ready handshakes on both sides and full throughput of one beat per cycle.

---
 rtl/sad_acc_if.sv | 28 ++
 rtl/sad_acc.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sad_acc_if.sv
// rtl/sad_acc_if.sv - beat input and frame result handshake bundle for the SAD engine
interface sad_acc_if #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int ACCW = 16,
  parameter int CW   = 8
);
  logic            in_vld;
  logic            in_rdy;
  logic            in_last;
  logic [N*W-1:0]  x;
  logic [N*W-1:0]  y;
  logic [ACCW-1:0] res;
  logic [CW-1:0]   res_cnt;
  logic            res_sat;
  logic            res_vld;
  logic            rdy_dn;

  modport master (
    output in_vld, in_last, x, y, rdy_dn,
    input  in_rdy, res, res_cnt, res_sat, res_vld
  );

  modport slave (
    input  in_vld, in_last, x, y, rdy_dn,
    output in_rdy, res, res_cnt, res_sat, res_vld
  );
endinterface

// File: rtl/sad_acc.sv
// rtl/sad_acc.sv - elastic 4-stage sum-of-absolute-differences engine with per-frame accumulation
module sad_acc #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int ACCW = 16,
  parameter int CW   = 8,
  parameter int SAT  = 1
) (
  input logic      clk,
  input logic      rst_n,
  sad_acc_if.slave s_if
);
  localparam int LW = $clog2(N);
  localparam int SW = W + LW;

  logic [W:0]      r_d1 [N];
  logic [W:0]      r_m2 [N];
  logic [SW-1:0]   r_sum3;
  logic            r_v1, r_v2, r_v3;
  logic            r_l1, r_l2, r_l3;

  logic [ACCW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_satf;
  logic [ACCW-1:0] r_res;
  logic [CW-1:0]   r_res_cnt;
  logic            r_res_sat;
  logic            r_res_vld;

  logic            w_rdy1, w_rdy2, w_rdy3, w_rdy4;
  logic            w_t1, w_t2, w_t3, w_t4;
  logic [SW-1:0]   w_tree;
  logic [ACCW:0]   w_wide;
  logic            w_ovf;
  logic [ACCW-1:0] w_acc_n;
  logic            w_sat_n;
  logic [CW-1:0]   w_cnt_n;

  // A pending result blocks S4 for every beat, so a stalled result also freezes accumulation.
  assign w_rdy4 = s_if.rdy_dn | ~r_res_vld;
  assign w_rdy3 = w_rdy4 | ~r_v3;
  assign w_rdy2 = w_rdy3 | ~r_v2;
  assign w_rdy1 = w_rdy2 | ~r_v1;
  assign s_if.in_rdy = w_rdy1;

  assign w_t1 = s_if.in_vld & w_rdy1;
  assign w_t2 = r_v1 & w_rdy2;
  assign w_t3 = r_v2 & w_rdy3;
  assign w_t4 = r_v3 & w_rdy4;

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < N; i++) begin
      w_tree = w_tree + SW'(r_m2[i]);
    end
  end

  assign w_wide  = {1'b0, r_acc} + (ACCW+1)'(r_sum3);
  assign w_ovf   = (SAT != 0) & w_wide[ACCW];
  assign w_acc_n = w_ovf ? '1 : w_wide[ACCW-1:0];
  assign w_sat_n = r_satf | w_ovf;
  assign w_cnt_n = (&r_cnt) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_rdy1) r_v1 <= s_if.in_vld;
      if (w_rdy2) r_v2 <= r_v1;
      if (w_rdy3) r_v3 <= r_v2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_t1) begin
      for (int i = 0; i < N; i++) begin
        r_d1[i] <= {1'b0, s_if.x[i*W +: W]} - {1'b0, s_if.y[i*W +: W]};
      end
      r_l1 <= s_if.in_last;
    end
    if (w_t2) begin
      for (int i = 0; i < N; i++) begin
        r_m2[i] <= r_d1[i][W] ? (~r_d1[i] + (W+1)'(1)) : r_d1[i];
      end
      r_l2 <= r_l1;
    end
    if (w_t3) begin
      r_sum3 <= w_tree;
      r_l3   <= r_l2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_satf    <= 1'b0;
      r_res     <= '0;
      r_res_cnt <= '0;
      r_res_sat <= 1'b0;
      r_res_vld <= 1'b0;
    end else begin
      if (w_t4) begin
        if (r_l3) begin
          r_res     <= w_acc_n;
          r_res_cnt <= w_cnt_n;
          r_res_sat <= w_sat_n;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_satf    <= 1'b0;
        end else begin
          r_acc  <= w_acc_n;
          r_cnt  <= w_cnt_n;
          r_satf <= w_sat_n;
        end
      end
      if (w_t4 && r_l3) r_res_vld <= 1'b1;
      else if (s_if.rdy_dn) r_res_vld <= 1'b0;
    end
  end

  assign s_if.res     = r_res;
  assign s_if.res_cnt = r_res_cnt;
  assign s_if.res_sat = r_res_sat;
  assign s_if.res_vld = r_res_vld;
endmodule
